stream_edge_filter: RTL and testbench

- Streaming 3x3 gradient edge detector for the YODA scanner pixel path. Replaces the whole-frame-in-memory filters.
- Pixels arrive raster-order over a valid/ready handshake. Two internal line buffers form the window.
- Kernel is run-time selectable, Prewitt or Sobel. One edge-magnitude pixel is emitted per pixel position, with border pixels forced to 0.

---
 rtl/stream_edge_filter.sv | 211 +++++++++++++++++++++
 tb/tb_stream_edge_filter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_edge_filter.sv
// rtl/stream_edge_filter.sv - streaming 3x3 Prewitt/Sobel edge magnitude filter
//
// Accepts a raster-order pixel stream and emits one edge-magnitude pixel per
// pixel position. Two line buffers plus a 3x2 window register hold the
// neighbourhood. The output lags the input by WIDTH+1 pixels. After the last
// input, the remaining WIDTH+1 outputs are flushed as zeros; they all lie on
// the border.
//
// Optional build macro: EDGE_THRESH_EN. When it is defined, the saturated
// magnitude is binarised against THRESH.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   mode                  0=Prewitt, 1=Sobel; captured on the first pixel of a frame
//   in_valid/in_ready     input handshake, in_pixel carries the pixel
//   out_valid/out_ready   output handshake, out_pixel carries the magnitude
//   out_last              marks the final output pixel of a frame
//   frame_done            one-cycle pulse after the final output is accepted

module stream_edge_filter #(
    parameter int WIDTH     = 45,
    parameter int HEIGHT    = 45,
    parameter int PIX_W     = 8,
    parameter int MAG_SHIFT = 2,
    parameter int THRESH    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_last,
    output logic             frame_done
);

    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int CNT_W = $clog2(NPIX);
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);
    localparam int FL_W  = $clog2(WIDTH + 1);
    localparam int ACC_W = PIX_W + 4;
    localparam logic [PIX_W-1:0] PIX_MAX = {PIX_W{1'b1}};
`ifdef EDGE_THRESH_EN
    localparam bit BIN_EN = 1'b1;
`else
    localparam bit BIN_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0] in_cnt;
    logic [COL_W-1:0] in_col;
    logic [COL_W-1:0] out_col;
    logic [ROW_W-1:0] out_row;
    logic [FL_W-1:0]  flush_cnt;
    logic             mode_q;

    // lb0 holds the previous row and lb1 the row before it, both indexed by column
    logic [PIX_W-1:0] lb0 [WIDTH];
    logic [PIX_W-1:0] lb1 [WIDTH];
    // Window columns left ([0]) and centre ([1]); the right column is the incoming one
    logic [PIX_W-1:0] win_t [2];
    logic [PIX_W-1:0] win_m [2];
    logic [PIX_W-1:0] win_b [2];

    logic [PIX_W-1:0] top_n, mid_n, bot_n;
    logic             slot_free, in_fire, run_emit, flush_emit, emit, border;

    logic signed [ACC_W-1:0] dx_t, dx_m, dx_b, dy_l, dy_c, dy_r, gx, gy;
    logic [ACC_W-1:0]        abs_gx, abs_gy, mag, shifted;
    logic [PIX_W-1:0]        sat, bin, edge_pix;

    function automatic logic signed [ACC_W-1:0] ext(input logic [PIX_W-1:0] v);
        return signed'({4'b0000, v});
    endfunction

    assign slot_free  = !out_valid || out_ready;
    assign in_ready   = !rst && (state != S_FLUSH) && slot_free;
    assign in_fire    = in_valid && in_ready;
    assign run_emit   = in_fire && (state == S_RUN);
    assign flush_emit = (state == S_FLUSH) && slot_free;
    assign emit       = run_emit || flush_emit;

    assign top_n = lb1[in_col];
    assign mid_n = lb0[in_col];
    assign bot_n = in_pixel;

    // Border positions also cover the window wrapping across a row boundary
    assign border = (out_row == '0) || (out_row == ROW_W'(HEIGHT - 1)) ||
                    (out_col == '0) || (out_col == COL_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FILL;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FILL: begin
                if (in_fire && in_cnt == CNT_W'(WIDTH)) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (in_fire && in_cnt == CNT_W'(NPIX - 1)) begin
                    state_nx = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (slot_free && flush_cnt == FL_W'(WIDTH)) begin
                    state_nx = S_FILL;
                end
            end
            default: state_nx = S_FILL;
        endcase
    end

    // Gradient: the centre coefficient is 1 for Prewitt and 2 for Sobel
    always_comb begin
        dx_t = ext(top_n) - ext(win_t[0]);
        dx_m = ext(mid_n) - ext(win_m[0]);
        dx_b = ext(bot_n) - ext(win_b[0]);
        dy_l = ext(win_b[0]) - ext(win_t[0]);
        dy_c = ext(win_b[1]) - ext(win_t[1]);
        dy_r = ext(bot_n) - ext(top_n);
        gx = dx_t + dx_b + (mode_q ? (dx_m <<< 1) : dx_m);
        gy = dy_l + dy_r + (mode_q ? (dy_c <<< 1) : dy_c);
        abs_gx = gx[ACC_W-1] ? -gx : gx;
        abs_gy = gy[ACC_W-1] ? -gy : gy;
        mag = abs_gx + abs_gy;
        shifted = mag >> MAG_SHIFT;
        sat = (shifted > ACC_W'(PIX_MAX)) ? PIX_MAX : shifted[PIX_W-1:0];
        bin = ({4'b0000, sat} >= ACC_W'(THRESH)) ? PIX_MAX : '0;
        edge_pix = BIN_EN ? bin : sat;
    end

    // Line buffers and window registers carry no reset; stale contents only
    // ever reach border positions.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            lb1[in_col] <= lb0[in_col];
            lb0[in_col] <= in_pixel;
            win_t[0] <= win_t[1];
            win_t[1] <= top_n;
            win_m[0] <= win_m[1];
            win_m[1] <= mid_n;
            win_b[0] <= win_b[1];
            win_b[1] <= bot_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt    <= '0;
            in_col    <= '0;
            out_col   <= '0;
            out_row   <= '0;
            flush_cnt <= '0;
            mode_q    <= 1'b0;
        end else begin
            if (in_fire) begin
                if (in_cnt == '0) begin
                    mode_q <= mode;
                end
                in_cnt <= (in_cnt == CNT_W'(NPIX - 1)) ? '0 : in_cnt + CNT_W'(1);
                in_col <= (in_col == COL_W'(WIDTH - 1)) ? '0 : in_col + COL_W'(1);
            end
            if (emit) begin
                if (out_col == COL_W'(WIDTH - 1)) begin
                    out_col <= '0;
                    out_row <= (out_row == ROW_W'(HEIGHT - 1)) ? '0 : out_row + ROW_W'(1);
                end else begin
                    out_col <= out_col + COL_W'(1);
                end
            end
            if (flush_emit) begin
                flush_cnt <= (flush_cnt == FL_W'(WIDTH)) ? '0 : flush_cnt + FL_W'(1);
            end
        end
    end

    // Output register only loads when the slot is free, so a stalled beat holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_pixel  <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_valid && out_ready && out_last;
            if (emit) begin
                out_valid <= 1'b1;
                out_pixel <= (flush_emit || border) ? '0 : edge_pix;
                out_last  <= flush_emit && (flush_cnt == FL_W'(WIDTH));
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_edge_filter.sv
// tb/tb_stream_edge_filter.sv - self-checking bench for stream_edge_filter on 5x5 frames

module tb_stream_edge_filter;

    localparam int W = 5;
    localparam int H = 5;
    localparam int N = W * H;
    localparam int MON = 512;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pixel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pixel;
    logic       out_last;
    logic       frame_done;

    always #5 clk = ~clk;

    stream_edge_filter #(
        .WIDTH(W), .HEIGHT(H), .PIX_W(8), .MAG_SHIFT(2), .THRESH(160)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_last(out_last), .frame_done(frame_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int mon_n      = 0;
    int done_total = 0;
    int mon_pix  [MON];
    int mon_last [MON];

    typedef struct {
        int pat;
        bit md;
        int exp [N];
    } vec_t;

    vec_t vecs [5];

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                mon_pix[mon_n % MON]  = int'(out_pixel);
                mon_last[mon_n % MON] = int'(out_last);
                mon_n = mon_n + 1;
            end
            if (frame_done) done_total = done_total + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [7:0] pix(input int pat, input int idx);
        int r = idx / W;
        int c = idx % W;
        case (pat)
            0:       return 8'd100;
            1:       return (c >= 2) ? 8'd200 : 8'd0;
            default: return (r == 0 || c == 0) ? 8'd0 : 8'd255;
        endcase
    endfunction

    function automatic int exp_val(input int v);
`ifdef EDGE_THRESH_EN
        return (v >= 160) ? 255 : 0;
`else
        return v;
`endif
    endfunction

    task automatic run_frame(input int pat, input bit md, input int n_in, input int exp_out,
                             input int stall_at, input int stall_len, output int base);
        int sent = 0;
        int cyc = 0;
        int stall_cnt = 0;
        bit stalling;
        bit have_held = 0;
        int held_pix = 0;
        int held_last = 0;
        base = mon_n;
        while (!(sent == n_in && (mon_n - base) >= exp_out) && cyc < 2000) begin
            @(posedge clk); #1;
            stalling = (stall_len > 0) && ((mon_n - base) >= stall_at) && (stall_cnt < stall_len);
            if (stalling) stall_cnt++;
            out_ready = !stalling;
            in_valid  = (sent < n_in);
            in_pixel  = pix(pat, sent % N);
            mode      = ((sent % N) == 0) ? md : !md;
            @(negedge clk);
            if (stalling && out_valid) begin
                chk("stall_in_ready", int'(in_ready), 0);
                if (have_held) begin
                    chk("stall_hold_pixel", int'(out_pixel), held_pix);
                    chk("stall_hold_last", int'(out_last), held_last);
                end else begin
                    have_held = 1;
                    held_pix  = int'(out_pixel);
                    held_last = int'(out_last);
                end
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        if (cyc >= 2000) begin
            n_checks++;
            $display("FAIL timeout: sent %0d of %0d, outputs %0d of %0d", sent, n_in, mon_n - base, exp_out);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input int base, input int v, input int dbase, input int nf);
        for (int f = 0; f < nf; f++) begin
            for (int i = 0; i < N; i++) begin
                int k = (base + f * N + i) % MON;
                chk($sformatf("v%0d_f%0d_pix%0d", v, f, i), mon_pix[k], exp_val(vecs[v].exp[i]));
                chk($sformatf("v%0d_f%0d_last%0d", v, f, i), mon_last[k], (i == N - 1) ? 1 : 0);
            end
        end
        chk($sformatf("v%0d_beat_count", v), mon_n - base, nf * N);
        chk($sformatf("v%0d_frame_done_count", v), done_total - dbase, nf);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_pixel"}, int'(out_pixel), 0);
        chk({tag, "_out_last"}, int'(out_last), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
    endtask

    initial begin
        int base;
        int dbase;

        vecs[0].pat = 0; vecs[0].md = 1'b0;
        vecs[0].exp = '{0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0};
        vecs[1].pat = 1; vecs[1].md = 1'b0;
        vecs[1].exp = '{0,0,0,0,0, 0,150,150,0,0, 0,150,150,0,0, 0,150,150,0,0, 0,0,0,0,0};
        vecs[2].pat = 1; vecs[2].md = 1'b1;
        vecs[2].exp = '{0,0,0,0,0, 0,200,200,0,0, 0,200,200,0,0, 0,200,200,0,0, 0,0,0,0,0};
        vecs[3].pat = 2; vecs[3].md = 1'b1;
        vecs[3].exp = '{0,0,0,0,0, 0,255,255,255,0, 0,255,0,0,0, 0,255,0,0,0, 0,0,0,0,0};
        vecs[4].pat = 2; vecs[4].md = 1'b0;
        vecs[4].exp = '{0,0,0,0,0, 0,255,191,191,0, 0,191,0,0,0, 0,191,0,0,0, 0,0,0,0,0};

        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", int'(in_ready), 1);

        for (int v = 0; v < 5; v++) begin
            dbase = done_total;
            run_frame(vecs[v].pat, vecs[v].md, N, N, 0, 0, base);
            check_frame(base, v, dbase, 1);
        end

        dbase = done_total;
        run_frame(1, 1'b1, N, N, 8, 10, base);
        check_frame(base, 2, dbase, 1);

        run_frame(1, 1'b1, 12, 0, 0, 0, base);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midframe_reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midframe_post_reset_in_ready", int'(in_ready), 1);
        dbase = done_total;
        run_frame(1, 1'b1, N, N, 0, 0, base);
        check_frame(base, 2, dbase, 1);

        dbase = done_total;
        run_frame(1, 1'b1, 2 * N, 2 * N, 0, 0, base);
        check_frame(base, 2, dbase, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
